// File: rtl/apuf_eval_ctrl.sv
// Evaluation sequencer for the adder arbiter PUF: holds a challenge, fires the race
// pulse NUM_EVAL times and returns a per-bit majority vote plus an instability mask.

module apuf_vote_lane #(
    parameter int NUM_EVAL = 5,
    parameter int ONES_W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic smp,
    input  logic bit_in,
    output logic vote,
    output logic unstable
);
    logic [ONES_W-1:0] ones;
    logic [ONES_W-1:0] ones_nxt;

    // Vote is taken on the count including the firing being sampled this edge.
    assign ones_nxt = ones + ONES_W'(bit_in);
    assign vote     = ones_nxt > ONES_W'(NUM_EVAL / 2);
    assign unstable = (ones_nxt != '0) && (ones_nxt != ONES_W'(NUM_EVAL));

    always_ff @(posedge clk) begin
        if (!rst_n)   ones <= '0;
        else if (clr) ones <= '0;
        else if (smp) ones <= ones_nxt;
    end
endmodule

module apuf_eval_ctrl #(
    parameter int CHAL_W     = 16,
    parameter int RESP_W     = 4,
    parameter int SETTLE_CYC = 4,
    parameter int PULSE_CYC  = 2,
    parameter int NUM_EVAL   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chal_valid,
    output logic              chal_ready,
    input  logic [CHAL_W-1:0] chal_data,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic              puf_pulse,
    input  logic [RESP_W-1:0] puf_response,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp_data,
    output logic [RESP_W-1:0] resp_unstable,
    output logic              busy
);
    localparam int MAXP   = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int PH_W   = $clog2(MAXP + 1);
    localparam int ONES_W = $clog2(NUM_EVAL + 1);

    typedef enum logic [2:0] {IDLE, SETUP, FIRE, RECOVER, DONE} state_t;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   phase;
    logic [ONES_W-1:0] eval_cnt;
    logic [ONES_W-1:0] eval_inc;
    logic              accept;
    logic              fire_last;
    logic [RESP_W-1:0] vote;
    logic [RESP_W-1:0] unst;

    assign eval_inc = eval_cnt + ONES_W'(1);

    always_comb begin
        state_nxt  = state;
        chal_ready = 1'b0;
        accept     = 1'b0;
        fire_last  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                chal_ready = 1'b1;
                if (chal_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP, RECOVER: begin
                if (phase == PH_W'(SETTLE_CYC - 1)) state_nxt = FIRE;
            end
            FIRE: begin
                if (phase == PH_W'(PULSE_CYC - 1)) begin
                    fire_last = 1'b1;
                    state_nxt = (eval_inc < ONES_W'(NUM_EVAL)) ? RECOVER : DONE;
                end
            end
            DONE: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            phase         <= '0;
            eval_cnt      <= '0;
            puf_pulse     <= 1'b0;
            puf_challenge <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_unstable <= '0;
        end else begin
            state      <= state_nxt;
            // Pulse and valid are decoded from the next state so both come straight off flops.
            puf_pulse  <= (state_nxt == FIRE);
            resp_valid <= (state_nxt == DONE);
            if (state_nxt != state)
                phase <= '0;
            else if (state == SETUP || state == FIRE || state == RECOVER)
                phase <= phase + PH_W'(1);
            if (accept) begin
                puf_challenge <= chal_data;
                eval_cnt      <= '0;
            end
            if (fire_last) eval_cnt <= eval_inc;
            if (fire_last && state_nxt == DONE) begin
                resp_data     <= vote;
                resp_unstable <= unst;
            end
        end
    end

    for (genvar i = 0; i < RESP_W; i++) begin : g_lane
        apuf_vote_lane #(.NUM_EVAL(NUM_EVAL), .ONES_W(ONES_W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (accept),
            .smp      (fire_last),
            .bit_in   (puf_response[i]),
            .vote     (vote[i]),
            .unstable (unst[i])
        );
    end
endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed bench: default-parameter sequencer with a table-driven PUF model, plus a
// minimal (1 firing, 1-cycle phases) instance for back-to-back timing.

module tb_apuf_eval_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    int          n_tests = 0;
    int          n_fail  = 0;

    // default instance
    logic        chal_valid, chal_ready, puf_pulse, resp_valid, resp_ready, busy;
    logic [15:0] chal_data, puf_challenge;
    logic [3:0]  puf_response, resp_data, resp_unstable;
    logic [3:0]  tab [8];
    int          fire_idx;
    logic        pulse_d;

    // minimal instance
    logic        b_cv, b_cr, b_pulse, b_rv, b_rr, b_busy;
    logic [15:0] b_cd, b_chal;
    logic [3:0]  b_resp, b_rd, b_ru;

    always #5 clk = ~clk;

    apuf_eval_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .chal_valid(chal_valid), .chal_ready(chal_ready),
        .chal_data(chal_data), .puf_challenge(puf_challenge), .puf_pulse(puf_pulse),
        .puf_response(puf_response), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_unstable(resp_unstable), .busy(busy)
    );

    apuf_eval_ctrl #(.SETTLE_CYC(1), .PULSE_CYC(1), .NUM_EVAL(1)) u_b (
        .clk(clk), .rst_n(rst_n), .chal_valid(b_cv), .chal_ready(b_cr),
        .chal_data(b_cd), .puf_challenge(b_chal), .puf_pulse(b_pulse),
        .puf_response(b_resp), .resp_valid(b_rv), .resp_ready(b_rr),
        .resp_data(b_rd), .resp_unstable(b_ru), .busy(b_busy)
    );

    // PUF model: firing index advances once the pulse has dropped.
    always @(posedge clk) begin
        pulse_d <= puf_pulse;
        if (!rst_n || (chal_valid && chal_ready)) fire_idx <= 0;
        else if (pulse_d && !puf_pulse)           fire_idx <= fire_idx + 1;
    end
    assign puf_response = tab[fire_idx[2:0]];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_tab(input logic [3:0] odd_r, input logic [3:0] even_r);
        for (int i = 0; i < 8; i++) tab[i] = (i % 2 == 0) ? odd_r : even_r;
    endtask

    // Accept a challenge and wait (bounded) for resp_valid; lat counts from the accept edge.
    task automatic run_chal(input logic [15:0] d, output int lat);
        chk("accept_ready", 32'(chal_ready), 32'd1);
        chal_valid = 1'b1;
        chal_data  = d;
        tick();
        chal_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int rv_seen;
        int k;
        rst_n = 1'b0; chal_valid = 1'b0; chal_data = '0; resp_ready = 1'b0;
        b_cv = 1'b0; b_cd = '0; b_rr = 1'b1; b_resp = '0;
        set_tab(4'b1010, 4'b1010);
        @(negedge clk);
        tick();
        chk("rst_outs", 32'({puf_pulse, resp_valid, busy, chal_ready}), 32'b0001);
        chk("rst_data", 32'({puf_challenge, resp_data, resp_unstable}), 32'd0);
        rst_n = 1'b1;
        tick();

        // stable response, with a busy-time challenge that must be ignored
        chal_valid = 1'b1; chal_data = 16'hA5C3;
        tick();
        chal_valid = 1'b0;
        chk("chal_T1", 32'(puf_challenge), 32'hA5C3);
        for (k = 1; k <= 31; k++) begin
            if (k == 5)  begin chal_valid = 1'b1; chal_data = 16'hFFFF; end
            if (k == 13) chal_valid = 1'b0;
            if (k <= 30) begin
                chk($sformatf("pulse_T%0d", k), 32'(puf_pulse),
                    32'((k >= 5) && (((k - 5) % 6) < 2)));
                chk($sformatf("rv_T%0d", k), 32'({resp_valid, busy}), 32'b01);
            end
            if (k < 31) tick();
        end
        chk("stable_rv", 32'({resp_valid, chal_ready}), 32'b10);
        chk("stable_data", 32'({resp_data, resp_unstable}), 32'({4'b1010, 4'b0000}));
        chk("ignore_chal", 32'(puf_challenge), 32'hA5C3);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("stable_idle", 32'({chal_ready, resp_valid, busy}), 32'b100);

        // noisy majority + backpressure
        set_tab(4'b0110, 4'b0111);
        run_chal(16'h3C3C, lat);
        chk("noisy_lat", 32'(lat), 32'd31);
        chk("noisy_data", 32'({resp_data, resp_unstable}), 32'({4'b0110, 4'b0001}));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_%0d", i), 32'({resp_valid, chal_ready, resp_data, resp_unstable}),
                32'({1'b1, 1'b0, 4'b0110, 4'b0001}));
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp_release", 32'({chal_ready, resp_valid}), 32'b10);

        // reset while the pulse is high
        set_tab(4'b0011, 4'b0011);
        chal_valid = 1'b1; chal_data = 16'h5555;
        tick();
        chal_valid = 1'b0;
        k = 0;
        while (!puf_pulse && k < 50) begin tick(); k++; end
        chk("reach_fire", 32'(puf_pulse), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_fire", 32'({puf_pulse, busy, resp_valid}), 32'b000);
        chk("rst_chal", 32'(puf_challenge), 32'd0);
        rv_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) rv_seen++;
            tick();
        end
        chk("rst_no_rv", 32'(rv_seen), 32'd0);
        run_chal(16'h1234, lat);
        chk("post_rst_lat", 32'(lat), 32'd31);
        chk("post_rst_data", 32'({resp_data, resp_unstable, puf_challenge}),
            32'({4'b0011, 4'b0000, 16'h1234}));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // back-to-back on the minimal instance
        b_resp = 4'b1001;
        chk("b_ready", 32'(b_cr), 32'd1);
        b_cv = 1'b1; b_cd = 16'h1111;
        tick();
        b_cd = 16'h2222;
        chk("b_busy1", 32'({b_busy, b_pulse, b_rv}), 32'b100);
        tick();
        chk("b_fire1", 32'({b_pulse, b_rv}), 32'b10);
        tick();
        chk("b_rv1", 32'({b_rv, b_cr, b_rd, b_ru}), 32'({1'b1, 1'b0, 4'b1001, 4'b0000}));
        b_resp = 4'b0100;
        tick();
        chk("b_idle", 32'({b_cr, b_rv, b_busy}), 32'b100);
        chk("b_chal_hold", 32'(b_chal), 32'h1111);
        tick();
        b_cv = 1'b0;
        chk("b_accept2", 32'({b_busy, b_chal}), 32'({1'b1, 16'h2222}));
        tick();
        tick();
        chk("b_rv2", 32'({b_rv, b_rd, b_ru}), 32'({1'b1, 4'b0100, 4'b0000}));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apuf_eval_ctrl.md
Name: apuf_eval_ctrl

Overview:
- Sequencer that sits directly upstream of the 16-bit adder arbiter PUF and drives its `pulse` and `challenge` inputs.
- Accepts one challenge per transaction over a valid/ready handshake and holds it stable while the adder chains settle.
- Fires the race pulse NUM_EVAL times and samples the PUF's 4-bit arbiter response on each firing.
- Returns a per-bit majority-voted response plus an instability mask over a second valid/ready handshake.

Parameters:
- CHAL_W, 16: challenge width; equals the PUF challenge width.
- RESP_W, 4: response width; equals the PUF response width.
- SETTLE_CYC, 4: cycles the challenge is held with pulse low before the first firing, and between firings. Must be >= 1.
- PULSE_CYC, 2: cycles pulse is held high per firing. Must be >= 1.
- NUM_EVAL, 5: firings per challenge. Must be odd and >= 1.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- chal_valid, input, 1: upstream challenge valid.
- chal_ready, output, 1: high only in IDLE.
- chal_data, input, CHAL_W: challenge, captured on accept.
- puf_challenge, output, CHAL_W: registered challenge to the PUF.
- puf_pulse, output, 1: registered race pulse to the PUF.
- puf_response, input, RESP_W: arbiter outputs from the PUF.
- resp_valid, output, 1: voted result available.
- resp_ready, input, 1: downstream accepts the result.
- resp_data, output, RESP_W: majority-voted response.
- resp_unstable, output, RESP_W: bit set if that bit disagreed across firings.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at an edge), values from the next cycle:
  - State is IDLE.
  - puf_pulse=0, puf_challenge=0, resp_valid=0, resp_data=0, resp_unstable=0, busy=0.
  - All counters are cleared.
- Reset mid-operation aborts the transaction: no partial result is ever presented, and pulse drops on the next edge.
- FSM states: IDLE, SETUP, FIRE, RECOVER, DONE.
- IDLE:
  - chal_ready=1.
  - When chal_valid&chal_ready at edge T: puf_challenge<=chal_data, ones counters cleared, eval counter=0, go to SETUP.
- SETUP:
  - puf_pulse=0.
  - Lasts exactly SETTLE_CYC cycles (T+1..T+SETTLE_CYC), then go to FIRE.
- FIRE:
  - puf_pulse=1 for exactly PULSE_CYC cycles.
  - On the edge ending the last FIRE cycle, puf_response is sampled: per bit i, ones[i] += puf_response[i].
  - The eval counter increments on that same edge.
  - If the updated counter < NUM_EVAL, go to RECOVER; else go to DONE.
- RECOVER:
  - puf_pulse=0 for SETTLE_CYC cycles, then go to FIRE.
- DONE:
  - resp_valid=1.
  - resp_data[i] = (ones[i] > NUM_EVAL/2).
  - resp_unstable[i] = (ones[i]!=0 && ones[i]!=NUM_EVAL).
  - Outputs are registered and held stable until resp_valid&resp_ready; return to IDLE on the next edge.
  - No same-cycle bypass: chal_ready cannot be high in a cycle where resp_valid is high.
- Outputs are glitch-free:
  - puf_pulse and puf_challenge are driven directly from flops.
  - puf_challenge is never changed outside the IDLE accept edge; it holds its value in all other states.
- Latency:
  - Accept edge to first resp_valid cycle = 1 + SETTLE_CYC + NUM_EVAL*PULSE_CYC + (NUM_EVAL-1)*SETTLE_CYC.
  - With defaults this is 31 cycles.
- Counter widths:
  - ones[i] is clog2(NUM_EVAL+1) bits and cannot overflow.
  - The phase counter is wide enough for max(SETTLE_CYC, PULSE_CYC).
- chal_valid while busy is ignored; the challenge is not captured, and the upstream must hold it.
- NUM_EVAL=1: no RECOVER is entered, and resp_unstable is always 0.

Test Plan:
- Stable response, defaults:
  - Stimulus: accept chal_data=16'hA5C3 at T; PUF model returns 4'b1010 on every firing.
  - Required: puf_challenge=16'hA5C3 from T+1.
  - Required: puf_pulse high at T+5..T+6, T+11..T+12, T+17..T+18, T+23..T+24, T+29..T+30.
  - Required: resp_valid at T+31 with resp_data=4'b1010 and resp_unstable=0.
- Noisy majority:
  - Stimulus: model returns 4'b0110 on firings 1, 3, 5 and 4'b0111 on firings 2, 4.
  - Required: resp_data=4'b0110, resp_unstable=4'b0001.
- Backpressure:
  - Stimulus: resp_ready=0 for 10 cycles after resp_valid.
  - Required: resp_valid, resp_data and resp_unstable are held constant; chal_ready=0 throughout.
  - Required: after the handshake, chal_ready=1 on the next cycle.
- Busy ignore:
  - Stimulus: assert chal_valid with 16'hFFFF during FIRE.
  - Required: puf_challenge is unchanged and no second accept occurs until IDLE.
- Reset mid-FIRE:
  - Stimulus: rst_n=0 for one edge while puf_pulse=1.
  - Required: next cycle puf_pulse=0, busy=0, resp_valid never rises.
  - Required: a new challenge is accepted normally.
- Back-to-back with NUM_EVAL=1, SETTLE_CYC=1, PULSE_CYC=1:
  - Stimulus: two challenges, resp_ready held high.
  - Required: each response arrives 3 cycles after its accept.
  - Required: the second accept occurs 1 cycle after the first response handshake.
